// File: rtl/pulse_seq_engine.sv
// rtl/pulse_seq_engine.sv - N-channel optical clock pulse sequencer
// Channels run IDLE/PULSE/DELAY/FIN once per iteration, launched globally or chained from k-1.
module pulse_seq_engine #(
  parameter int N_CH   = 16,
  parameter int CNT_W  = 17,
  parameter int MULT_W = 5,
  parameter int REP_W  = 8,
  localparam int AW    = $clog2(N_CH) + 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_we,
  input  logic [AW-1:0]     cfg_addr,
  input  logic [CNT_W-1:0]  cfg_data,
  input  logic              start,
  input  logic              abort,
  input  logic [REP_W-1:0]  burst,
  output logic [N_CH-1:0]   ch_out,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {S_IDLE, S_PULSE, S_DELAY, S_FIN} ch_state_t;

  logic             busy_q;
  logic             done_q;
  logic [REP_W-1:0] rep_q;
  logic [N_CH-1:0]  fin;
  logic [N_CH-1:0]  pulse;
  logic             boundary;
  logic             fire;
  logic             cfg_ok;
  logic [AW-1:0]    cfg_ch;

  assign cfg_ch   = cfg_addr >> 2;
  assign cfg_ok   = cfg_we && !busy_q;
  assign boundary = busy_q && (&fin);
  assign fire     = !abort && ((start && !busy_q) || (boundary && (rep_q != '0)));

  assign ch_out = pulse;
  assign busy   = busy_q;
  assign done   = done_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= 1'b0;
      done_q <= 1'b0;
      rep_q  <= '0;
    end else if (abort) begin
      busy_q <= 1'b0;
      done_q <= 1'b0;
      rep_q  <= '0;
    end else begin
      done_q <= 1'b0;
      if (start && !busy_q) begin
        busy_q <= 1'b1;
        rep_q  <= burst;
      end else if (boundary) begin
        if (rep_q != '0) begin
          rep_q <= rep_q - REP_W'(1);
        end else begin
          busy_q <= 1'b0;
          done_q <= 1'b1;
        end
      end
    end
  end

  for (genvar k = 0; k < N_CH; k++) begin : g_ch
    ch_state_t         st_q, st_d;
    logic [CNT_W-1:0]  dur_q, dly_q, in_q, in_d;
    logic [MULT_W-1:0] mp_q, ml_q, out_q, out_d;
    logic              mode_q, trig, launch, idle_eff, sel;

    assign sel = cfg_ok && (cfg_ch == AW'(k));

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        dur_q  <= '0;
        dly_q  <= '0;
        mp_q   <= '0;
        ml_q   <= '0;
        mode_q <= 1'b0;
      end else if (sel) begin
        case (cfg_addr[1:0])
          2'd0: dur_q <= cfg_data;
          2'd1: dly_q <= cfg_data;
          2'd2: begin
            mp_q   <= cfg_data[MULT_W-1:0];
            ml_q   <= cfg_data[2*MULT_W-1:MULT_W];
            mode_q <= cfg_data[2*MULT_W];
          end
          default: ;
        endcase
      end
    end

    if (k == 0) begin : g_head
      assign trig = fire;
    end else begin : g_link
      assign trig = mode_q ? fire : g_ch[k-1].launch;
    end

    // At an iteration boundary FIN channels act as IDLE so a refire can relaunch them at once.
    assign idle_eff = (st_q == S_IDLE) || ((st_q == S_FIN) && boundary);

    // Nested countdown: in_q walks D (or L) down to 1, out_q counts the remaining multiplier laps.
    always_comb begin
      st_d   = st_q;
      in_d   = in_q;
      out_d  = out_q;
      launch = 1'b0;
      if (idle_eff) begin
        st_d = S_IDLE;
        if (trig) begin
          if (dur_q != '0) begin
            st_d  = S_PULSE;
            in_d  = dur_q;
            out_d = mp_q;
          end else if (dly_q != '0) begin
            st_d  = S_DELAY;
            in_d  = dly_q;
            out_d = ml_q;
          end else begin
            st_d   = S_FIN;
            launch = 1'b1;
          end
        end
      end else begin
        case (st_q)
          S_PULSE: begin
            if (in_q == CNT_W'(1)) begin
              if (out_q == '0) begin
                if (dly_q != '0) begin
                  st_d  = S_DELAY;
                  in_d  = dly_q;
                  out_d = ml_q;
                end else begin
                  st_d   = S_FIN;
                  launch = 1'b1;
                end
              end else begin
                out_d = out_q - MULT_W'(1);
                in_d  = dur_q;
              end
            end else begin
              in_d = in_q - CNT_W'(1);
            end
          end
          S_DELAY: begin
            if (in_q == CNT_W'(1)) begin
              if (out_q == '0) begin
                st_d   = S_FIN;
                launch = 1'b1;
              end else begin
                out_d = out_q - MULT_W'(1);
                in_d  = dly_q;
              end
            end else begin
              in_d = in_q - CNT_W'(1);
            end
          end
          default: ;
        endcase
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        st_q  <= S_IDLE;
        in_q  <= '0;
        out_q <= '0;
      end else if (abort) begin
        st_q  <= S_IDLE;
        in_q  <= '0;
        out_q <= '0;
      end else begin
        st_q  <= st_d;
        in_q  <= in_d;
        out_q <= out_d;
      end
    end

    assign fin[k]   = (st_q == S_FIN);
    assign pulse[k] = (st_q == S_PULSE);
  end

endmodule

// File: tb/tb_pulse_seq_engine.sv
// tb/tb_pulse_seq_engine.sv - scoreboard bench for pulse_seq_engine
// Expected per-cycle outputs come from an interval-arithmetic model of each run.
module tb_pulse_seq_engine;

  localparam int N_CH   = 4;
  localparam int CNT_W  = 17;
  localparam int MULT_W = 5;
  localparam int REP_W  = 8;
  localparam int AW     = $clog2(N_CH) + 2;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             cfg_we = 1'b0;
  logic [AW-1:0]    cfg_addr = '0;
  logic [CNT_W-1:0] cfg_data = '0;
  logic             start = 1'b0;
  logic             abort = 1'b0;
  logic [REP_W-1:0] burst = '0;
  logic [N_CH-1:0]  ch_out;
  logic             busy;
  logic             done;

  pulse_seq_engine #(.N_CH(N_CH), .CNT_W(CNT_W), .MULT_W(MULT_W), .REP_W(REP_W)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .start(start), .abort(abort), .burst(burst), .ch_out(ch_out), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [N_CH-1:0] ch;
    logic            busy;
    logic            done;
  } obs_t;

  obs_t exp_q[$];
  obs_t mon_exp, mon_act;
  int   n_checks = 0;
  int   n_pass = 0;

  int m_d[N_CH], m_l[N_CH], m_mp[N_CH], m_ml[N_CH];
  int m_mode[N_CH];

  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      mon_exp = exp_q.pop_front();
      mon_act = {ch_out, busy, done};
      n_checks++;
      if (mon_act === mon_exp) n_pass++;
      else $display("FAIL out_trace t=%0t: got ch=%b busy=%b done=%b, expected ch=%b busy=%b done=%b",
                    $time, mon_act.ch, mon_act.busy, mon_act.done, mon_exp.ch, mon_exp.busy, mon_exp.done);
    end
  end

  function automatic void model_reset();
    for (int k = 0; k < N_CH; k++) begin
      m_d[k] = 0; m_l[k] = 0; m_mp[k] = 0; m_ml[k] = 0; m_mode[k] = 0;
    end
  endfunction

  function automatic void model_write(input int ch, input int field, input int data);
    case (field)
      0: m_d[ch] = data;
      1: m_l[ch] = data;
      2: begin
        m_mp[ch]   = data & ((1 << MULT_W) - 1);
        m_ml[ch]   = (data >> MULT_W) & ((1 << MULT_W) - 1);
        m_mode[ch] = (data >> (2 * MULT_W)) & 1;
      end
      default: ;
    endcase
  endfunction

  // Trace cycle c is c cycles after the start cycle; cut>0 means abort is driven in cycle cut.
  task automatic push_run(input int reps, input int cut_req, input bit tail, output int cut);
    int f, b, t, plen, dlen, last;
    int launch[N_CH];
    int ps[$], pe[$], pk[$];
    obs_t o;
    f = 0;
    for (int it = 0; it <= reps; it++) begin
      b = f;
      for (int k = 0; k < N_CH; k++) begin
        t    = (k == 0 || m_mode[k] == 1) ? f : launch[k-1];
        plen = m_d[k] * (m_mp[k] + 1);
        dlen = m_l[k] * (m_ml[k] + 1);
        if (plen > 0) begin
          ps.push_back(t + 1); pe.push_back(t + plen); pk.push_back(k);
        end
        launch[k] = t + plen + dlen;
        if (launch[k] > b) b = launch[k];
      end
      f = b + 1;
    end
    if (cut_req < 0) cut = $urandom_range(1, f);
    else cut = cut_req;
    last = (cut > 0) ? cut : f + 1;
    for (int c = 1; c <= last; c++) begin
      o = '0;
      for (int i = 0; i < ps.size(); i++)
        if (c >= ps[i] && c <= pe[i]) o.ch[pk[i]] = 1'b1;
      o.busy = (c <= f);
      o.done = (c == f + 1);
      exp_q.push_back(o);
    end
    if (tail) repeat (3) exp_q.push_back('0);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() > 0) begin
      n_checks++;
      $display("FAIL drain_timeout: %0d entries left, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic cfg_write(input int ch, input int field, input int data, input bit locked);
    @(negedge clk);
    cfg_we   = 1'b1;
    cfg_addr = AW'((ch << 2) | field);
    cfg_data = CNT_W'(data);
    @(negedge clk);
    cfg_we = 1'b0;
    if (!locked) model_write(ch, field, data);
  endtask

  task automatic set_ch(input int k, input int d, input int l, input int mp, input int ml, input int mode);
    cfg_write(k, 0, d, 1'b0);
    cfg_write(k, 1, l, 1'b0);
    cfg_write(k, 2, (mode << (2 * MULT_W)) | (ml << MULT_W) | mp, 1'b0);
    cfg_write(k, 3, $urandom_range(1, 1000), 1'b0);
  endtask

  task automatic run(input int reps, input int cut_req);
    int cut;
    @(negedge clk);
    start = 1'b1;
    burst = REP_W'(reps);
    push_run(reps, cut_req, 1'b1, cut);
    @(negedge clk);
    start = 1'b0;
    if (cut > 0) begin
      repeat (cut - 1) @(negedge clk);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
    end
    drain();
  endtask

  task automatic check_idle(input string name);
    n_checks++;
    if ({ch_out, busy, done} === '0) n_pass++;
    else $display("FAIL %s: got ch=%b busy=%b done=%b, required all 0", name, ch_out, busy, done);
  endtask

  task automatic plan_cfg();
    set_ch(0, 3, 2, 0, 0, 1);
    set_ch(1, 2, 0, 0, 0, 0);
    set_ch(2, 1, 0, 0, 0, 0);
    set_ch(3, 5, 0, 0, 0, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cut;
    model_reset();
    repeat (3) @(negedge clk);
    check_idle("reset_state");
    rst_n = 1'b1;

    plan_cfg();
    run(0, 0);

    run(0, 6);
    run(0, 0);

    // config write and start while busy must both be ignored
    @(negedge clk);
    start = 1'b1;
    burst = '0;
    push_run(0, 0, 1'b1, cut);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    cfg_write(1, 0, 7, 1'b1);
    @(negedge clk);
    start = 1'b1;
    burst = REP_W'(3);
    @(negedge clk);
    start = 1'b0;
    burst = '0;
    drain();
    run(0, 0);

    @(negedge clk);
    start = 1'b1;
    abort = 1'b1;
    repeat (3) exp_q.push_back('0);
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    drain();

    set_ch(0, 3, 1, 2, 3, 1);
    set_ch(1, 1, 0, 0, 0, 0);
    set_ch(2, 0, 0, 0, 0, 0);
    set_ch(3, 0, 0, 0, 0, 0);
    run(0, 0);

    set_ch(0, 2, 1, 0, 0, 0);
    set_ch(1, 0, 0, 0, 0, 0);
    run(2, 0);

    set_ch(0, 2, 0, 0, 0, 1);
    set_ch(1, 0, 0, 0, 0, 0);
    set_ch(2, 2, 1, 0, 0, 0);
    set_ch(3, 1, 0, 0, 0, 1);
    run(0, 0);

    for (int r = 0; r < 8; r++) begin
      for (int k = 0; k < N_CH; k++)
        set_ch(k, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2),
               $urandom_range(0, 1), $urandom_range(0, 1));
      run($urandom_range(0, 2), ($urandom_range(0, 2) == 0) ? -1 : 0);
    end

    plan_cfg();
    @(negedge clk);
    start = 1'b1;
    burst = '0;
    push_run(0, 2, 1'b0, cut);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1 check_idle("async_reset_mid_pulse");
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    run(0, 0);

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
